// File: rtl/apb_slave_responder.sv
// APB slave responder backed by a byte-strobed word memory, with programmable wait states.
// Optional error injection on a chosen address when APB_SLV_ERR_INJ_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a setup phase (psel=1, penable=0)
// ACCESS | setup latched; counting down wait states, then completing
module apb_slave_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int WAIT_W     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [WAIT_W-1:0]       cfg_wait_cycles,
`ifdef APB_SLV_ERR_INJ_EN
    input  logic                    err_inj_en,
    input  logic [ADDR_WIDTH-1:0]   err_inj_addr,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [CNT_W-1:0]        xfer_count
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(BYTES);
    localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state, state_nxt;

    logic                    wr_q;
    logic [MIDX_W-1:0]       midx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]        strb_q;
    logic [WAIT_W-1:0]       wcnt;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   idx_in;
    logic [MIDX_W-1:0]       midx_in;
    logic                    in_range_in;
    logic                    inj_hit;
    logic                    err_in;
    logic                    setup;
    logic                    complete;

    assign idx_in      = paddr >> OFF;
    assign midx_in     = idx_in[MIDX_W-1:0];
    assign in_range_in = 32'(idx_in) < 32'(MEM_DEPTH);

`ifdef APB_SLV_ERR_INJ_EN
    assign inj_hit = err_inj_en && (paddr == err_inj_addr);
`else
    assign inj_hit = 1'b0;
`endif

    assign err_in = !in_range_in || inj_hit;

    // Handshake outputs come only from registers, never from the bus inputs.
    assign pready   = (state == ACCESS) && (wcnt == '0);
    assign pslverr  = pready && err_q;

    assign setup    = (state == IDLE) && psel && !penable;
    assign complete = (state == ACCESS) && pready && psel && penable;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || complete) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata     <= '0;
            wr_q       <= 1'b0;
            midx_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            wcnt       <= '0;
            err_q      <= 1'b0;
            xfer_count <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (setup) begin
                wr_q    <= pwrite;
                midx_q  <= midx_in;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                wcnt    <= cfg_wait_cycles;
                err_q   <= err_in;
                prdata  <= (!pwrite && !err_in) ? mem[midx_in] : '0;
            end else if (state == ACCESS && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end

            if (complete) begin
                xfer_count <= xfer_count + 1'b1;
                // err_q also guarantees midx_q is in range before touching memory.
                if (wr_q && !err_q) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (strb_q[b]) begin
                            mem[midx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
